top_laji_intel_knights_landing: RTL and testbench

//  FPGA top level of the Laji CPU: single-cycle MIPS32-subset core with internal instruction/data RAM,

---
 rtl/top_laji_intel_knights_landing.sv | 197 +++++++++++++++++++
 tb/tb_top_laji_intel_knights_landing.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/top_laji_intel_knights_landing.sv
// Laji CPU FPGA top: single-cycle MIPS32-subset core with on-chip RAMs,
// syscall pause/halt and an 8-digit multiplexed hex display.
module top_laji_intel_knights_landing #(
    parameter string PROG_FILE = "benchmark.hex",
    parameter int    IMEM_AW   = 10,
    parameter int    DMEM_AW   = 10,
    parameter int    SCAN_DIV  = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        resume,
    input  logic [15:0] swt,
    output logic [7:0]  seg_n,
    output logic [7:0]  an_n
);

    typedef enum logic [1:0] {S_RUN, S_PAUSE, S_HALT} state_t;

    logic [31:0] imem_q [2**IMEM_AW];
    logic [31:0] dmem_q [2**DMEM_AW];
    logic [31:0] rf_q   [32];
    logic [31:0] pc_q, disp_q, cyc_q, ins_q;
    state_t      state_q;
    logic [23:0] div_q;
    logic [2:0]  rsm_q;
    logic [2:0]  scan_q;
    logic [SCAN_DIV-1:0] sdiv_q;

    // FPGA bitstream image: code and data RAM cleared
    initial begin
        for (int i = 0; i < 2**IMEM_AW; i++) imem_q[i] = '0;
        for (int i = 0; i < 2**DMEM_AW; i++) dmem_q[i] = '0;
    end

    logic [31:0] ir, rs_v, rt_v, simm, zimm, pc4, npc, wd, mrd, dval;
    logic [DMEM_AW-1:0] midx, dsel;
    logic [4:0]  wa;
    logic [3:0]  nib;
    logic [6:0]  font;
    logic        we, mwe, sys, step_en, go, rsm_edge;

    assign ir   = imem_q[IMEM_AW'(pc_q >> 2)];
    assign rs_v = rf_q[ir[25:21]];
    assign rt_v = rf_q[ir[20:16]];
    assign simm = {{16{ir[15]}}, ir[15:0]};
    assign zimm = {16'b0, ir[15:0]};
    assign pc4  = pc_q + 32'd4;
    assign midx = DMEM_AW'((rs_v + simm) >> 2);
    assign mrd  = dmem_q[midx];
    assign dsel = DMEM_AW'(swt[15:5]);

    assign rsm_edge = rsm_q[1] & ~rsm_q[2];
    assign go       = step_en && (state_q == S_RUN);

    always_comb begin
        unique case (swt[1:0])
            2'b11:   step_en = 1'b1;
            2'b10:   step_en = (div_q[7:0] == 8'd0);
            2'b01:   step_en = (div_q[15:0] == 16'd0);
            default: step_en = (div_q == 24'd0);
        endcase
    end

    always_comb begin
        we  = 1'b0;
        wa  = ir[20:16];
        wd  = '0;
        mwe = 1'b0;
        sys = 1'b0;
        npc = pc4;
        unique case (ir[31:26])
            6'h00: begin
                we = 1'b1;
                wa = ir[15:11];
                unique case (ir[5:0])
                    6'h20, 6'h21: wd = rs_v + rt_v;
                    6'h22, 6'h23: wd = rs_v - rt_v;
                    6'h24: wd = rs_v & rt_v;
                    6'h25: wd = rs_v | rt_v;
                    6'h26: wd = rs_v ^ rt_v;
                    6'h27: wd = ~(rs_v | rt_v);
                    6'h2A: wd = {31'b0, $signed(rs_v) < $signed(rt_v)};
                    6'h2B: wd = {31'b0, rs_v < rt_v};
                    6'h00: wd = rt_v << ir[10:6];
                    6'h02: wd = rt_v >> ir[10:6];
                    6'h03: wd = 32'($signed(rt_v) >>> ir[10:6]);
                    6'h04: wd = rt_v << rs_v[4:0];
                    6'h06: wd = rt_v >> rs_v[4:0];
                    6'h07: wd = 32'($signed(rt_v) >>> rs_v[4:0]);
                    6'h08: begin we = 1'b0; npc = rs_v; end
                    6'h0C: begin we = 1'b0; sys = 1'b1; end
                    default: we = 1'b0;
                endcase
            end
            6'h02: npc = {pc4[31:28], ir[25:0], 2'b00};
            6'h03: begin
                npc = {pc4[31:28], ir[25:0], 2'b00};
                we  = 1'b1;
                wa  = 5'd31;
                wd  = pc4;
            end
            6'h04: if (rs_v == rt_v) npc = pc4 + (simm << 2);
            6'h05: if (rs_v != rt_v) npc = pc4 + (simm << 2);
            6'h08, 6'h09: begin we = 1'b1; wd = rs_v + simm; end
            6'h0A: begin we = 1'b1; wd = {31'b0, $signed(rs_v) < $signed(simm)}; end
            6'h0B: begin we = 1'b1; wd = {31'b0, rs_v < simm}; end
            6'h0C: begin we = 1'b1; wd = rs_v & zimm; end
            6'h0D: begin we = 1'b1; wd = rs_v | zimm; end
            6'h0E: begin we = 1'b1; wd = rs_v ^ zimm; end
            6'h0F: begin we = 1'b1; wd = {ir[15:0], 16'b0}; end
            6'h23: begin we = 1'b1; wd = mrd; end
            6'h2B: mwe = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            disp_q  <= '0;
            cyc_q   <= '0;
            ins_q   <= '0;
            state_q <= S_RUN;
            div_q   <= '0;
            rsm_q   <= '0;
            scan_q  <= '0;
            sdiv_q  <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            div_q  <= div_q + 24'd1;
            rsm_q  <= {rsm_q[1:0], resume};
            sdiv_q <= sdiv_q + 1'b1;
            if (&sdiv_q) scan_q <= scan_q + 3'd1;
            if (state_q == S_RUN) cyc_q <= cyc_q + 32'd1;
            unique case (state_q)
                S_RUN: if (step_en) begin
                    ins_q <= ins_q + 32'd1;
                    if (we && wa != 5'd0) rf_q[wa] <= wd;
                    if (sys && rf_q[2] == 32'd10) begin
                        state_q <= S_HALT;
                    end else begin
                        pc_q <= npc;
                        if (sys) begin
                            disp_q  <= rf_q[4];
                            state_q <= S_PAUSE;
                        end
                    end
                end
                S_PAUSE: if (rsm_edge) state_q <= S_RUN;
                default: ;
            endcase
        end
    end

    // rst_n gate: reset state is RUN with the divider at 0
    always_ff @(posedge clk) begin
        if (rst_n && go && mwe) dmem_q[midx] <= rt_v;
    end

    always_comb begin
        unique case (swt[4:2])
            3'b000:  dval = disp_q;
            3'b001:  dval = pc_q;
            3'b010:  dval = ins_q;
            3'b011:  dval = cyc_q;
            3'b100:  dval = dmem_q[dsel];
            default: dval = '0;
        endcase
    end

    assign nib = dval[{scan_q, 2'b00} +: 4];

    always_comb begin
        unique case (nib)
            4'h0: font = 7'h40;
            4'h1: font = 7'h79;
            4'h2: font = 7'h24;
            4'h3: font = 7'h30;
            4'h4: font = 7'h19;
            4'h5: font = 7'h12;
            4'h6: font = 7'h02;
            4'h7: font = 7'h78;
            4'h8: font = 7'h00;
            4'h9: font = 7'h10;
            4'hA: font = 7'h08;
            4'hB: font = 7'h03;
            4'hC: font = 7'h46;
            4'hD: font = 7'h21;
            4'hE: font = 7'h06;
            default: font = 7'h0E;
        endcase
    end

    assign seg_n = {1'b1, font};
    assign an_n  = ~(8'd1 << scan_q);

endmodule

// File: tb/tb_top_laji_intel_knights_landing.sv
// Bench for the Laji CPU top: programs loaded into imem, results
// observed through the scanned 7-segment display.
module tb_top_laji_intel_knights_landing;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        resume = 1'b0;
    logic [15:0] swt = 16'h0003;
    logic [7:0]  seg_n, an_n;

    int total = 0;
    int bad = 0;
    int ncyc;

    string       tagq [$];
    logic [31:0] expq [$];
    logic [31:0] prog [$];

    localparam logic [7:0] FONT [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    top_laji_intel_knights_landing #(
        .PROG_FILE(""),
        .SCAN_DIV (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .resume(resume),
        .swt   (swt),
        .seg_n (seg_n),
        .an_n  (an_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ncyc <= 0;
        else        ncyc <= ncyc + 1;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        tagq.push_back(tag);
        expq.push_back(v);
    endtask

    task automatic pop_chk(input logic [31:0] got);
        string t;
        logic [31:0] e;
        if (expq.size() == 0) begin
            chk("sb_empty", 32'(expq.size()), 32'd1);
            return;
        end
        t = tagq.pop_front();
        e = expq.pop_front();
        chk(t, got, e);
    endtask

    function automatic logic [31:0] ri(input int op, rs, rt,
                                       input logic [15:0] imm);
        return {6'(op), 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] rr(input int rs, rt, rd, sh, fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] jj(input int op, input int tgt);
        return {6'(op), 26'(tgt >> 2)};
    endfunction

    task automatic load();
        for (int i = 0; i < 1024; i++) dut.imem_q[i] = 32'h0;
        foreach (prog[i]) dut.imem_q[i] = prog[i];
    endtask

    // Scan all eight digits and rebuild the shown 32-bit value
    task automatic read_disp(input logic [2:0] sel, input logic [10:0] addr);
        bit ok, segok;
        logic [31:0] v;
        swt = {addr, sel, swt[1:0]};
        v = '0;
        segok = 1'b1;
        for (int d = 0; d < 8; d++) begin
            ok = 1'b0;
            for (int t = 0; t < 64 && !ok; t++) begin
                @(negedge clk);
                if (an_n == ~(8'd1 << d)) ok = 1'b1;
            end
            if (!ok) chk("scan_timeout", {31'b0, ok}, 32'd1);
            ok = 1'b0;
            for (int i = 0; i < 16; i++) begin
                if (seg_n == FONT[i]) begin
                    v[4*d +: 4] = 4'(i);
                    ok = 1'b1;
                end
            end
            if (!ok) segok = 1'b0;
        end
        if (!segok) chk("seg_code", {31'b0, segok}, 32'd1);
        pop_chk(v);
    endtask

    task automatic pulse_resume();
        resume = 1'b1;
        repeat (3) @(negedge clk);
        resume = 1'b0;
    endtask

    initial begin
        prog = '{ri(9, 0, 4, 16'h1234), ri(9, 0, 2, 16'd34), 32'hC,
                 ri(9, 4, 4, 16'd1), 32'hC, ri(9, 4, 4, 16'd1), 32'hC,
                 jj(2, 28)};
        #1;
        load();
        @(negedge clk);
        push("rst_an", 32'hFE);
        pop_chk({24'b0, an_n});
        push("rst_seg", 32'hC0);
        pop_chk({24'b0, seg_n});

        rst_n = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            push($sformatf("scan%0d", k), {24'b0, ~(8'd1 << (k % 8))});
            pop_chk({24'b0, an_n});
            repeat (4) @(negedge clk);
        end

        push("pause_disp", 32'h0000_1234); read_disp(3'b000, 11'd0);
        push("pause_pc", 32'd12);          read_disp(3'b001, 11'd0);
        push("pause_ins", 32'd3);          read_disp(3'b010, 11'd0);
        push("pause_cyc", 32'd3);          read_disp(3'b011, 11'd0);

        swt[1:0] = 2'b10;
        pulse_resume();
        repeat (40) @(negedge clk);
        pulse_resume();
        repeat (1200) @(negedge clk);
        push("resume_disp", 32'h0000_1235); read_disp(3'b000, 11'd0);
        push("resume_pc", 32'd20);          read_disp(3'b001, 11'd0);

        rst_n = 1'b0;
        prog = '{};
        load();
        swt = {11'd0, 3'b001, 2'b10};
        @(negedge clk);
        rst_n = 1'b1;
        repeat (600) @(negedge clk);
        push("slow_pc3", 32'd12); read_disp(3'b001, 11'd0);
        push("slow_ins3", 32'd3); read_disp(3'b010, 11'd0);
        while (ncyc < 900) @(negedge clk);
        push("slow_pc4", 32'd16); read_disp(3'b001, 11'd0);
        push("slow_ins4", 32'd4); read_disp(3'b010, 11'd0);

        rst_n = 1'b0;
        prog = '{ri(9, 0, 4, 16'd0), ri(9, 0, 8, 16'd1), ri(9, 0, 9, 16'd11),
                 rr(4, 8, 4, 0, 'h21), ri(9, 8, 8, 16'd1),
                 ri(5, 8, 9, 16'hFFFD), ri('h0F, 0, 10, 16'hDEAD),
                 ri('h0D, 10, 10, 16'hBEEF), ri('h2B, 0, 10, 16'd20),
                 ri('h23, 0, 11, 16'd20), rr(0, 10, 12, 4, 'h03),
                 ri('h2B, 0, 12, 16'd24), rr(10, 4, 13, 0, 'h2A),
                 rr(10, 4, 14, 0, 'h2B), rr(13, 14, 15, 0, 'h27),
                 ri('h2B, 0, 15, 16'd28), rr(11, 13, 16, 0, 'h21),
                 ri('h2B, 0, 16, 16'd32), jj(3, 80), 32'h0,
                 ri('h2B, 0, 31, 16'd36), ri('h2B, 0, 4, 16'd40),
                 ri(9, 0, 2, 16'd10), 32'hC};
        load();
        swt = 16'h0003;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        push("halt_pc", 32'd92);         read_disp(3'b001, 11'd0);
        push("halt_cyc", 32'd50);        read_disp(3'b011, 11'd0);
        push("mem_w5", 32'hDEAD_BEEF);   read_disp(3'b100, 11'd5);
        push("mem_sra", 32'hFDEA_DBEE);  read_disp(3'b100, 11'd6);
        push("mem_nor", 32'hFFFF_FFFE);  read_disp(3'b100, 11'd7);
        push("mem_lw", 32'hDEAD_BEF0);   read_disp(3'b100, 11'd8);
        push("mem_ra", 32'd76);          read_disp(3'b100, 11'd9);
        push("mem_sum", 32'd55);         read_disp(3'b100, 11'd10);
        pulse_resume();
        repeat (20) @(negedge clk);
        push("halt_pc2", 32'd92);        read_disp(3'b001, 11'd0);
        push("halt_cyc2", 32'd50);       read_disp(3'b011, 11'd0);

        rst_n = 1'b0;
        prog = '{ri(9, 0, 4, 16'h1234), ri(9, 0, 2, 16'd34), 32'hC,
                 jj(2, 12)};
        load();
        swt = {11'd0, 3'b001, 2'b10};
        @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        push("async_an", 32'hFE);
        pop_chk({24'b0, an_n});
        push("async_seg", 32'hC0);
        pop_chk({24'b0, seg_n});
        @(negedge clk);
        swt = 16'h0003;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        push("rerun_disp", 32'h0000_1234); read_disp(3'b000, 11'd0);
        push("rerun_pc", 32'd12);          read_disp(3'b001, 11'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
